alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a small 4-bit ALU.
// One operation is in flight at a time: accept in IDLE, compute in EXEC,
// then hold the response in RESP until the consumer takes it.
module alu_arbiter #(
   parameter int PRIO_FIXED = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [2:0] req0_op,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [2:0] req1_op,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [3:0] rsp_result,
   output logic       rsp_c,
   output logic       rsp_z,
   output logic       rsp_n,
   output logic       rsp_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t     state;
   logic       last_grant;
   logic       grant;
   logic       accept_en;
   logic       cap_id;
   logic [2:0] cap_op;
   logic [3:0] cap_a;
   logic [3:0] cap_b;
   logic [4:0] sum;
   logic [3:0] alu_result;
   logic       alu_c;
   logic       alu_err;

   // Pick the winner among the currently valid requesters; on a tie either
   // requester 0 wins outright or the one not served last time goes next.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         if (PRIO_FIXED != 0) begin
            grant = 1'b0;
         end else begin
            grant = ~last_grant;
         end
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   // Readies are offered only while idle and out of reset, so the handshake
   // itself decides which operation starts.
   assign accept_en  = (state == IDLE) && !rst && (req0_valid || req1_valid);
   assign req0_ready = accept_en && !grant;
   assign req1_ready = accept_en && grant;

   // ALU on the captured operands; illegal opcodes produce zero with err set.
   always_comb begin
      sum        = 5'd0;
      alu_result = 4'd0;
      alu_c      = 1'b0;
      alu_err    = 1'b0;
      case (cap_op)
         3'b000: begin
            sum        = {1'b0, cap_a} + {1'b0, cap_b};
            alu_result = sum[3:0];
            alu_c      = sum[4];
         end
         3'b001: begin
            sum        = {1'b0, cap_a} + {1'b0, ~cap_b} + 5'd1;
            alu_result = sum[3:0];
            alu_c      = sum[4];
         end
         3'b010:  alu_result = cap_a & cap_b;
         3'b011:  alu_result = cap_a | cap_b;
         3'b100:  alu_result = ~cap_a;
         default: alu_err    = 1'b1;
      endcase
   end

   // Control FSM: capture on accept, register the ALU result, hold until taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cap_id     <= 1'b0;
         cap_op     <= 3'd0;
         cap_a      <= 4'd0;
         cap_b      <= 4'd0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= 4'd0;
         rsp_c      <= 1'b0;
         rsp_z      <= 1'b0;
         rsp_n      <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_valid || req1_valid) begin
                  cap_id     <= grant;
                  cap_op     <= grant ? req1_op : req0_op;
                  cap_a      <= grant ? req1_a : req0_a;
                  cap_b      <= grant ? req1_b : req0_b;
                  last_grant <= grant;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               rsp_id     <= cap_id;
               rsp_result <= alu_result;
               rsp_c      <= alu_c;
               rsp_z      <= (alu_result == 4'd0);
               rsp_n      <= alu_result[3];
               rsp_err    <= alu_err;
               rsp_valid  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
